pbit_sweep_scheduler: RTL

- Sequences asynchronous-style p-bit updates for a sparse Ising network (e.g. the 5-p-bit full adder) from one clock.
- Issues one-hot update enables in round-robin order, with a programmable settle gap between updates so LFSR/biased-RNG pipelines can advance.
- After each full sweep, snapshots the p-bit state into a single-entry valid/ready output buffer for the ILA/readout path.
- Sits between the run-control logic and the p-bit update array.

---
 rtl/pbit_sweep_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pbit_sweep_scheduler.sv
// Round-robin one-hot p-bit update sequencer with settle gaps and a per-sweep state snapshot.
// Latency: upd_en is registered (valid in the UPDATE cycle itself); the snapshot is visible the cycle after SAMPLE.
// Backpressure: single-entry sample buffer; an unread sample is overwritten and flags sticky overflow.
// Option: define PBIT_SCHED_SKIP_CLAMPED_EN to drop clamped p-bits' slots from the sweep entirely.
module pbit_sweep_scheduler #(
    parameter int N_PBITS = 5,
    parameter int GAP_W   = 4,
    parameter int SWEEP_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [N_PBITS-1:0] clamp_mask,
    input  logic [N_PBITS-1:0] pbit_state,
    output logic [N_PBITS-1:0] upd_en,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [N_PBITS-1:0] sample_data,
    output logic               overflow
);

    localparam int IW = $clog2(N_PBITS + 1);
    localparam logic [IW-1:0] NONE = IW'(N_PBITS);

`ifdef PBIT_SCHED_SKIP_CLAMPED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_UPDATE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic [SWEEP_W-1:0] num_q;
    logic [SWEEP_W-1:0] cnt_q;
    logic [N_PBITS-1:0] clamp_q;
    logic [N_PBITS-1:0] upd_en_q;
    logic [N_PBITS-1:0] sample_data_q;
    logic               busy_q;
    logic               done_q;
    logic               sample_valid_q;
    logic               overflow_q;

    // First slot at or after 'from' that owns a cycle; NONE when the sweep is exhausted.
    function automatic logic [IW-1:0] next_slot(input logic [IW-1:0] from,
                                                input logic [N_PBITS-1:0] mask);
        logic [IW-1:0] r;
        r = NONE;
        for (int i = N_PBITS - 1; i >= 0; i--) begin
            if (i >= int'(from) && !(SKIP && mask[i])) r = IW'(i);
        end
        return r;
    endfunction

    function automatic logic [N_PBITS-1:0] slot_en(input logic [IW-1:0] idx,
                                                   input logic [N_PBITS-1:0] mask);
        return (N_PBITS'(1) << idx) & ~mask;
    endfunction

    logic [IW-1:0]      start_idx;
    logic [IW-1:0]      adv_idx;
    logic [IW-1:0]      wrap_idx;
    logic [SWEEP_W-1:0] cnt_inc;
    logic               last_sweep;
    logic               adv_now;

    assign start_idx  = next_slot('0, clamp_mask);
    assign adv_idx    = next_slot(idx_q + IW'(1), clamp_q);
    assign wrap_idx   = next_slot('0, clamp_q);
    assign cnt_inc    = cnt_q + SWEEP_W'(1);
    assign last_sweep = (num_q != '0) && (cnt_inc == num_q);
    assign adv_now    = !stop && (((state_q == S_UPDATE) && (gap_q == '0)) ||
                                  ((state_q == S_SETTLE) && (gap_cnt_q == GAP_W'(1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            gap_q          <= '0;
            gap_cnt_q      <= '0;
            num_q          <= '0;
            cnt_q          <= '0;
            clamp_q        <= '0;
            upd_en_q       <= '0;
            sample_data_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            upd_en_q <= '0;
            done_q   <= 1'b0;
            if (sample_valid_q && sample_ready) sample_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        gap_q      <= gap_cycles;
                        num_q      <= num_sweeps;
                        clamp_q    <= clamp_mask;
                        cnt_q      <= '0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (start_idx == NONE) begin
                            idx_q   <= '0;
                            state_q <= S_SAMPLE;
                        end else begin
                            idx_q    <= start_idx;
                            upd_en_q <= slot_en(start_idx, clamp_mask);
                            state_q  <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_q != '0) begin
                        gap_cnt_q <= gap_q;
                        state_q   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (gap_cnt_q != GAP_W'(1)) begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (stop) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        sample_data_q  <= pbit_state;
                        sample_valid_q <= 1'b1;
                        if (sample_valid_q && !sample_ready) overflow_q <= 1'b1;
                        cnt_q <= cnt_inc;
                        if (last_sweep) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (wrap_idx == NONE) begin
                            idx_q   <= '0;
                            state_q <= S_SAMPLE;
                        end else begin
                            idx_q    <= wrap_idx;
                            upd_en_q <= slot_en(wrap_idx, clamp_q);
                            state_q  <= S_UPDATE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Shared exit from the end of an UPDATE or SETTLE slot.
            if (adv_now) begin
                if (adv_idx == NONE) begin
                    idx_q   <= '0;
                    state_q <= S_SAMPLE;
                end else begin
                    idx_q    <= adv_idx;
                    upd_en_q <= slot_en(adv_idx, clamp_q);
                    state_q  <= S_UPDATE;
                end
            end
        end
    end

    assign upd_en       = upd_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sweep_count  = cnt_q;
    assign sample_valid = sample_valid_q;
    assign sample_data  = sample_data_q;
    assign overflow     = overflow_q;

endmodule
